// File: rtl/traffic_light_fsm.sv
// Two-way intersection controller with an optional pedestrian walk phase.
// The controller steps through fixed-length phases and advances only on enabled cycles. All outputs are registered.
module traffic_light_fsm #(
  parameter int T_GREEN  = 12,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       phase_tick
);

  typedef enum logic [2:0] {
    NS_GREEN, NS_YELLOW, ALL_RED1, EW_GREEN, EW_YELLOW, ALL_RED2, WALK
  } state_t;

  typedef enum logic {DIR_NS, DIR_EW} dir_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } lamps_t;

  state_t     state, state_next;
  dir_t       next_dir, dir_next;
  logic [7:0] count, count_next;
  logic       ped_pend, ped_pend_next;
  logic       entering_walk;
  lamps_t     lamps_next;

  // Counter reload value: a phase of length T runs for counts T-1 down to 0.
  function automatic logic [7:0] phase_len(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   phase_len = 8'(T_GREEN - 1);
      NS_YELLOW, EW_YELLOW: phase_len = 8'(T_YELLOW - 1);
      ALL_RED1, ALL_RED2:   phase_len = 8'(T_ALLRED - 1);
      WALK:                 phase_len = 8'(T_WALK - 1);
      default:              phase_len = 8'(T_GREEN - 1);
    endcase
  endfunction

  function automatic lamps_t decode_lamps(input state_t s);
    case (s)
      NS_GREEN:  decode_lamps = '{ns: LAMP_GREEN,  ew: LAMP_RED,    walk: 1'b0};
      NS_YELLOW: decode_lamps = '{ns: LAMP_YELLOW, ew: LAMP_RED,    walk: 1'b0};
      EW_GREEN:  decode_lamps = '{ns: LAMP_RED,    ew: LAMP_GREEN,  walk: 1'b0};
      EW_YELLOW: decode_lamps = '{ns: LAMP_RED,    ew: LAMP_YELLOW, walk: 1'b0};
      WALK:      decode_lamps = '{ns: LAMP_RED,    ew: LAMP_RED,    walk: 1'b1};
      default:   decode_lamps = '{ns: LAMP_RED,    ew: LAMP_RED,    walk: 1'b0};
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
    state_next = state;
    dir_next   = next_dir;
    count_next = count;

    if (enable) begin
      if (count == 8'd0) begin
        case (state)
          NS_GREEN:  state_next = NS_YELLOW;
          NS_YELLOW: state_next = ALL_RED1;
          ALL_RED1: begin
            state_next = ped_pend ? WALK : EW_GREEN;
            dir_next   = DIR_EW;
          end
          EW_GREEN:  state_next = EW_YELLOW;
          EW_YELLOW: state_next = ALL_RED2;
          ALL_RED2: begin
            state_next = ped_pend ? WALK : NS_GREEN;
            dir_next   = DIR_NS;
          end
          WALK:      state_next = (next_dir == DIR_EW) ? EW_GREEN : NS_GREEN;
          default:   state_next = NS_GREEN;
        endcase
        count_next = phase_len(state_next);
      end else begin
        count_next = count - 8'd1;
      end
    end

    // A request arriving on the edge that enters WALK survives for the next cycle.
    entering_walk = (state_next == WALK) && (state != WALK);
    ped_pend_next = ped_req | (ped_pend & ~entering_walk);
    lamps_next    = decode_lamps(state_next);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= NS_GREEN;
      count      <= 8'(T_GREEN - 1);
      next_dir   <= DIR_NS;
      ped_pend   <= 1'b0;
      ns_light   <= LAMP_GREEN;
      ew_light   <= LAMP_RED;
      walk       <= 1'b0;
      phase_tick <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      next_dir   <= dir_next;
      ped_pend   <= ped_pend_next;
      ns_light   <= lamps_next.ns;
      ew_light   <= lamps_next.ew;
      walk       <= lamps_next.walk;
      phase_tick <= (state_next != state);
    end
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm: table-driven phase sequences fed through a scoreboard queue.
// A second instance with all phase lengths set to 1 covers the minimum-length case.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       reset, reset_b, enable, ped_req;
  logic [2:0] ns_a, ew_a, ns_b, ew_b;
  logic       walk_a, tick_a, walk_b, tick_b;

  traffic_light_fsm #(.T_GREEN(4), .T_YELLOW(2), .T_ALLRED(1), .T_WALK(3)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .ped_req(ped_req),
    .ns_light(ns_a), .ew_light(ew_a), .walk(walk_a), .phase_tick(tick_a)
  );

  traffic_light_fsm #(.T_GREEN(1), .T_YELLOW(1), .T_ALLRED(1), .T_WALK(1)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable), .ped_req(ped_req),
    .ns_light(ns_b), .ew_light(ew_b), .walk(walk_b), .phase_tick(tick_b)
  );

  always #5 clk = ~clk;

  // Lamp patterns {ns, ew, walk}
  localparam logic [6:0] L_NSG = {3'b001, 3'b100, 1'b0};
  localparam logic [6:0] L_NSY = {3'b010, 3'b100, 1'b0};
  localparam logic [6:0] L_AR  = {3'b100, 3'b100, 1'b0};
  localparam logic [6:0] L_EWG = {3'b100, 3'b001, 1'b0};
  localparam logic [6:0] L_EWY = {3'b100, 3'b010, 1'b0};
  localparam logic [6:0] L_WLK = {3'b100, 3'b100, 1'b1};

  typedef struct {
    logic       en;
    logic       ped;
    logic [7:0] exp;  // {ns, ew, walk, phase_tick} after the edge
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // n enabled cycles showing the given lamps; tick expected on the first one when first_tick is set.
  function automatic void add_phase(input logic [6:0] lamps, input int n, input bit first_tick,
                                    input int ped_at);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.en  = 1'b1;
      v.ped = (i == ped_at);
      v.exp = {lamps, first_tick && (i == 0)};
      vecs.push_back(v);
    end
  endfunction

  function automatic void add_hold(input logic [6:0] lamps, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.en  = 1'b0;
      v.ped = 1'b0;
      v.exp = {lamps, 1'b0};
      vecs.push_back(v);
    end
  endfunction

  function automatic void add_period(input bit ns_tick);
    add_phase(L_NSG, 4, ns_tick, -1);
    add_phase(L_NSY, 2, 1'b1, -1);
    add_phase(L_AR,  1, 1'b1, -1);
    add_phase(L_EWG, 4, 1'b1, -1);
    add_phase(L_EWY, 2, 1'b1, -1);
    add_phase(L_AR,  1, 1'b1, -1);
  endfunction

  task automatic run_table(input bit use_b, input string tag);
    logic [7:0] act, want;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      enable  = vecs[i].en;
      ped_req = vecs[i].ped;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      act  = use_b ? {ns_b, ew_b, walk_b, tick_b} : {ns_a, ew_a, walk_a, tick_a};
      want = exp_q.pop_front();
      check($sformatf("%s[%0d] lamps/tick", tag, i), 32'(act), 32'(want));
      check($sformatf("%s[%0d] onehot", tag, i), 32'($onehot(act[7:5]) && $onehot(act[4:2])), 32'd1);
    end
    enable  = 1'b0;
    ped_req = 1'b0;
    vecs.delete();
  endtask

  initial begin
    reset   = 1'b0;
    reset_b = 1'b1;
    enable  = 1'b0;
    ped_req = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("reset outputs a", 32'({ns_a, ew_a, walk_a, tick_a}), 32'({L_NSG, 1'b0}));
    check("reset outputs b", 32'({ns_b, ew_b, walk_b, tick_b}), 32'({L_NSG, 1'b0}));
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Free run: the first NS_GREEN edge is cycle 1, so three samples remain in it.
    add_phase(L_NSG, 3, 1'b0, -1);
    add_phase(L_NSY, 2, 1'b1, -1);
    add_phase(L_AR,  1, 1'b1, -1);
    add_phase(L_EWG, 4, 1'b1, -1);
    add_phase(L_EWY, 2, 1'b1, -1);
    add_phase(L_AR,  1, 1'b1, -1);
    add_period(1'b1);
    run_table(1'b0, "free");

    // Pedestrian pulse in NS_GREEN, plus a 5-cycle enable gap mid EW_GREEN; next period has no WALK.
    add_phase(L_NSG, 4, 1'b1, 1);
    add_phase(L_NSY, 2, 1'b1, -1);
    add_phase(L_AR,  1, 1'b1, -1);
    add_phase(L_WLK, 3, 1'b1, -1);
    add_phase(L_EWG, 2, 1'b1, -1);
    add_hold(L_EWG, 5);
    add_phase(L_EWG, 2, 1'b0, -1);
    add_phase(L_EWY, 2, 1'b1, -1);
    add_phase(L_AR,  1, 1'b1, -1);
    add_period(1'b1);
    run_table(1'b0, "ped");

    // Request on the edge entering WALK is served again after the next ALL_RED.
    add_phase(L_NSG, 4, 1'b1, 1);
    add_phase(L_NSY, 2, 1'b1, -1);
    add_phase(L_AR,  1, 1'b1, -1);
    add_phase(L_WLK, 3, 1'b1, 0);
    add_phase(L_EWG, 4, 1'b1, -1);
    add_phase(L_EWY, 2, 1'b1, -1);
    add_phase(L_AR,  1, 1'b1, -1);
    add_phase(L_WLK, 3, 1'b1, -1);
    add_period(1'b1);
    run_table(1'b0, "simul");

    // Reach mid-WALK with another request pending, then reset asynchronously.
    add_phase(L_NSG, 4, 1'b1, 1);
    add_phase(L_NSY, 2, 1'b1, -1);
    add_phase(L_AR,  1, 1'b1, -1);
    add_phase(L_WLK, 2, 1'b1, 0);
    run_table(1'b0, "prewalk");
    @(negedge clk) reset = 1'b1;
    #1;
    check("async reset mid-walk", 32'({ns_a, ew_a, walk_a, tick_a}), 32'({L_NSG, 1'b0}));
    @(negedge clk) reset = 1'b0;
    add_phase(L_NSG, 3, 1'b0, -1);
    add_phase(L_NSY, 2, 1'b1, -1);
    add_phase(L_AR,  1, 1'b1, -1);
    add_phase(L_EWG, 4, 1'b1, -1);
    add_phase(L_EWY, 2, 1'b1, -1);
    add_phase(L_AR,  1, 1'b1, -1);
    add_phase(L_NSG, 1, 1'b1, -1);
    run_table(1'b0, "postrst");

    // Minimum lengths: every edge changes phase, so the tick stays high.
    @(negedge clk) reset_b = 1'b0;
    for (int p = 0; p < 2; p++) begin
      add_phase(L_NSY, 1, 1'b1, -1);
      add_phase(L_AR,  1, 1'b1, -1);
      add_phase(L_EWG, 1, 1'b1, -1);
      add_phase(L_EWY, 1, 1'b1, -1);
      add_phase(L_AR,  1, 1'b1, -1);
      add_phase(L_NSG, 1, 1'b1, -1);
    end
    run_table(1'b1, "min");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
